serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 110 +++++++++++
 tb/tb_serial_adder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell built from two HA instances, carry held in a register.
// Operands are shifted LSB first; the sum is assembled MSB-inserted over WIDTH RUN cycles.

module HA (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// state | meaning
// IDLE  | in_ready=1, waiting for an operand handshake
// RUN   | one bit pair per cycle, WIDTH cycles
// DONE  | out_valid=1, sum/cout held until out_ready
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [WIDTH-1:0]  sum_sr;
    logic [WIDTH-1:0]  sum_shift;
    logic              carry_q;
    logic [CNT_W-1:0]  cnt;

    logic s0, c0, c1, bit_sum, carry_next;

    HA u_ha0 (.a(a_sr[0]), .b(b_sr[0]), .s(s0),      .c(c0));
    HA u_ha1 (.a(s0),      .b(carry_q), .s(bit_sum), .c(c1));

    assign carry_next = c0 | c1;

    // A single-bit result register has no upper bits to shift down.
    if (WIDTH == 1) begin : g_w1
        assign sum_shift = bit_sum;
    end else begin : g_wn
        assign sum_shift = {bit_sum, sum_sr[WIDTH-1:1]};
    end

    assign sum  = sum_sr;
    assign cout = carry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        carry_q  <= cin;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    sum_sr  <= sum_shift;
                    carry_q <= carry_next;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1 (two instances, one selected at a time).
// Expected results come from plain integer addition of the operands.

module tb_serial_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a, b;
    logic        cin;
    logic        sel;          // 0 drives the WIDTH=8 instance, 1 the WIDTH=1 instance

    logic       d8_in_ready, d8_out_valid, d8_cout;
    logic [7:0] d8_sum;
    logic       d1_in_ready, d1_out_valid, d1_cout;
    logic [0:0] d1_sum;

    int checks = 0;
    int errors = 0;
    int cyc_count = 0;
    int prev_accept = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_count <= cyc_count + 1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel), .in_ready(d8_in_ready),
        .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .out_valid(d8_out_valid), .out_ready(out_ready & ~sel),
        .sum(d8_sum), .cout(d8_cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel), .in_ready(d1_in_ready),
        .a(a[0:0]), .b(b[0:0]), .cin(cin),
        .out_valid(d1_out_valid), .out_ready(out_ready & sel),
        .sum(d1_sum), .cout(d1_cout)
    );

    logic        cur_in_ready, cur_out_valid, cur_cout;
    logic [31:0] cur_sum;
    assign cur_in_ready  = sel ? d1_in_ready  : d8_in_ready;
    assign cur_out_valid = sel ? d1_out_valid : d8_out_valid;
    assign cur_cout      = sel ? d1_cout      : d8_cout;
    assign cur_sum       = sel ? {31'b0, d1_sum} : {24'b0, d8_sum};

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        int          stall;
        bit          hold;
        logic [31:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Behavioural model: the result is just the arithmetic sum split at bit w.
    task automatic model(input int w, input logic [31:0] oa, input logic [31:0] ob, input logic oc,
                         output logic [31:0] es, output logic ec);
        longint mask, t;
        mask = (64'd1 << w) - 1;
        t = (longint'(oa) & mask) + (longint'(ob) & mask) + longint'(oc);
        es = 32'(t & mask);
        ec = t[w];
    endtask

    task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic oc,
                          input int stall, input bit hold, input bit gap,
                          input logic [31:0] es, input logic ec);
        int w, n, lat;
        w = sel ? 1 : 8;
        a = oa; b = ob; cin = oc; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!cur_in_ready && n < 50) begin tick(); n++; end
        if (!cur_in_ready) begin timeout("wait_in_ready"); in_valid = 1'b0; return; end
        tick();
        if (gap && prev_accept >= 0) chk("accept_spacing", 32'(cyc_count - prev_accept), 32'(w + 2));
        prev_accept = cyc_count;
        if (!hold) in_valid = 1'b0;
        lat = 0;
        while (!cur_out_valid && lat < 50) begin
            if (hold) begin a = $urandom; b = $urandom; cin = 1'($urandom); end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        if (!cur_out_valid) begin timeout("wait_out_valid"); return; end
        chk("latency", 32'(lat), 32'(w));
        chk("sum", cur_sum, es);
        chk("cout", 32'(cur_cout), 32'(ec));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_sum", cur_sum, es);
            chk("stall_cout", 32'(cur_cout), 32'(ec));
            chk("stall_in_ready", 32'(cur_in_ready), 32'd0);
            chk("stall_out_valid", 32'(cur_out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_in_ready", 32'(cur_in_ready), 32'd1);
        chk("post_hs_out_valid", 32'(cur_out_valid), 32'd0);
    endtask

    vec_t vecs8[7];
    vec_t vecs1[3];

    initial begin
        logic [31:0] es, ra, rb;
        logic        ec, rc;
        int          n;

        vecs8[0] = '{32'hFF, 32'h01, 1'b0, 0, 1'b0, 32'h00, 1'b1};
        vecs8[1] = '{32'h5A, 32'hA5, 1'b1, 0, 1'b0, 32'h00, 1'b1};
        vecs8[2] = '{32'h12, 32'h34, 1'b0, 5, 1'b0, 32'h46, 1'b0};
        vecs8[3] = '{32'h7F, 32'h01, 1'b0, 0, 1'b1, 32'h80, 1'b0};
        vecs8[4] = '{32'hFF, 32'hFF, 1'b1, 2, 1'b0, 32'hFF, 1'b1};
        vecs8[5] = '{32'h00, 32'h00, 1'b1, 0, 1'b1, 32'h01, 1'b0};
        vecs8[6] = '{32'h00, 32'h00, 1'b0, 0, 1'b0, 32'h00, 1'b0};
        vecs1[0] = '{32'h1, 32'h1, 1'b1, 0, 1'b0, 32'h1, 1'b1};
        vecs1[1] = '{32'h1, 32'h0, 1'b0, 3, 1'b0, 32'h1, 1'b0};
        vecs1[2] = '{32'h0, 32'h1, 1'b1, 0, 1'b1, 32'h0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sel = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst8_in_ready", 32'(d8_in_ready), 32'd1);
        chk("rst8_out_valid", 32'(d8_out_valid), 32'd0);
        chk("rst8_sum", 32'(d8_sum), 32'd0);
        chk("rst8_cout", 32'(d8_cout), 32'd0);
        chk("rst1_in_ready", 32'(d1_in_ready), 32'd1);
        chk("rst1_sum", 32'(d1_sum), 32'd0);

        foreach (vecs8[i])
            run_op(vecs8[i].a, vecs8[i].b, vecs8[i].cin, vecs8[i].stall, vecs8[i].hold, 1'b0,
                   vecs8[i].exp_sum, vecs8[i].exp_cout);

        // Reset mid-RUN at cnt=3: operation discarded, no result appears.
        a = 32'hC3; b = 32'h3C; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrun_rst_in_ready", 32'(d8_in_ready), 32'd1);
        chk("midrun_rst_out_valid", 32'(d8_out_valid), 32'd0);
        chk("midrun_rst_sum", 32'(d8_sum), 32'd0);
        chk("midrun_rst_cout", 32'(d8_cout), 32'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (d8_out_valid) n++; end
        chk("midrun_rst_no_valid", 32'(n), 32'd0);
        run_op(32'h80, 32'h80, 1'b0, 0, 1'b0, 1'b0, 32'h00, 1'b1);

        // Reset while a result is pending in DONE.
        a = 32'hF0; b = 32'h0F; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!d8_out_valid && n < 50) begin tick(); n++; end
        chk("done_reached", 32'(d8_out_valid), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("done_rst_out_valid", 32'(d8_out_valid), 32'd0);
        chk("done_rst_cout", 32'(d8_cout), 32'd0);

        prev_accept = -1;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            model(8, ra, rb, rc, es, ec);
            run_op(ra, rb, rc, 0, 1'b0, 1'b1, es, ec);
        end

        sel = 1'b1;
        foreach (vecs1[i])
            run_op(vecs1[i].a, vecs1[i].b, vecs1[i].cin, vecs1[i].stall, vecs1[i].hold, 1'b0,
                   vecs1[i].exp_sum, vecs1[i].exp_cout);
        prev_accept = -1;
        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            model(1, ra, rb, rc, es, ec);
            run_op(ra, rb, rc, 0, 1'b0, 1'b1, es, ec);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
